// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// This is the central stall/flush sequencer for the 5-stage RV32I pipeline.
// It combines three event sources into one set of per-register write-enables
// and flushes:
//   - the load-use stop from the hazard unit,
//   - the EX-stage branch/jump redirect,
//   - the multi-cycle data-memory handshake.
// It also runs the post-reset pipeline-clear sequence and a memory-wait
// watchdog.
//
// Build option:
//   PIPE_PERF_CNT_EN  When defined, the four performance counters are built.
//                     When undefined, the counter logic is left out and the
//                     perf_* ports are tied to zero.
//
// Parameters:
//   RST_BUBBLES  Number of INIT cycles that flush every pipeline register
//                after reset (>=1).
//   MEM_TIMEOUT  Number of MEM_WAIT cycles before mem_err is raised
//                (1..255).
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   lu_stop        load-use hazard (ID needs a load result still in EX)
//   ex_redirect    taken branch / jal / jalr resolved in EX
//   mem_req        MEM stage holds a load or store
//   mem_ready      data memory completes the access this cycle
//   pc_we          PC load enable
//   pc_sel         0 = PC+4, 1 = EX redirect target
//   if_id_we       IF/ID enable
//   if_id_flush    IF/ID clear
//   id_ex_we       ID/EX enable
//   id_ex_flush    ID/EX clear
//   ex_mem_we      EX/MEM enable
//   ex_mem_flush   EX/MEM clear
//   mem_wb_flush   MEM/WB clear (MEM/WB has no enable)
//   stall          high whenever pc_we is low
//   mem_err        sticky watchdog flag
//   perf_cycles    RUN + MEM_WAIT cycle count
//   perf_lu        load-use bubbles inserted
//   perf_mem       memory stall cycles
//   perf_flush     redirects taken
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int RST_BUBBLES = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lu_stop,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        if_id_we,
    output logic        if_id_flush,
    output logic        id_ex_we,
    output logic        id_ex_flush,
    output logic        ex_mem_we,
    output logic        ex_mem_flush,
    output logic        mem_wb_flush,
    output logic        stall,
    output logic        mem_err,
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_lu,
    output logic [31:0] perf_mem,
    output logic [31:0] perf_flush
);

    // The bubble counter only needs to count up to RST_BUBBLES-1.
    localparam int BW = (RST_BUBBLES < 2) ? 1 : $clog2(RST_BUBBLES);
    localparam logic [BW-1:0] BUB_LAST = BW'(RST_BUBBLES - 1);
    localparam logic [7:0]    TMO      = 8'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [BW-1:0] bub_cnt_reg, bub_cnt_next;
    logic [7:0]    wait_cnt_reg, wait_cnt_next;
    logic          mem_err_reg, mem_err_next;

    logic memstall;       // the memory access is not finished this cycle
    logic active;         // the pipeline is out of its reset-clear sequence
    logic take_redirect;  // a redirect is actually applied this cycle
    logic take_bubble;    // a load-use bubble is actually inserted this cycle

    // ------------------------------------------------------------------
    // Event qualification
    // ------------------------------------------------------------------
    always_comb begin
        memstall = 1'b0;
        case (state_reg)
            ST_RUN:      memstall = mem_req & ~mem_ready;
            // Once waiting, only mem_ready matters. The MEM stage is frozen,
            // so mem_req is held by construction.
            ST_MEM_WAIT: memstall = ~mem_ready;
            default:     memstall = 1'b0;
        endcase
    end

    assign active = (state_reg == ST_RUN) || (state_reg == ST_MEM_WAIT);

    // A memory stall freezes the EX and ID stages. Their requests are
    // therefore held and get another chance on the release cycle.
    assign take_redirect = active & ~memstall & ex_redirect;

    // A redirect squashes the instruction that raised lu_stop, so no bubble
    // is needed in that case.
    assign take_bubble = active & ~memstall & ~ex_redirect & lu_stop;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        bub_cnt_next  = bub_cnt_reg;
        wait_cnt_next = wait_cnt_reg;
        mem_err_next  = mem_err_reg;

        case (state_reg)
            ST_INIT: begin
                if (bub_cnt_reg == BUB_LAST) begin
                    state_next = ST_RUN;
                end else begin
                    bub_cnt_next = bub_cnt_reg + 1'b1;
                end
            end

            ST_RUN: begin
                if (memstall) begin
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = 8'd1;
                end
            end

            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_next    = ST_RUN;
                    wait_cnt_next = 8'd0;
                end else begin
                    // wait_cnt_reg holds the index of the current MEM_WAIT
                    // cycle. The flag therefore rises at the end of the
                    // MEM_TIMEOUT-th waiting cycle.
                    if (wait_cnt_reg >= TMO) begin
                        mem_err_next = 1'b1;
                    end
                    if (wait_cnt_reg != 8'hFF) begin
                        wait_cnt_next = wait_cnt_reg + 8'd1;
                    end
                end
            end

            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (combinational from state and inputs)
    // ------------------------------------------------------------------
    always_comb begin
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        if_id_we     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_we     = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_we    = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;

        if (!active) begin
            // Reset clear: hold the PC and flush every pipeline register.
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (memstall) begin
            // Freeze PC..EX/MEM. Send a NOP into WB so that the stalled
            // access does not retire twice.
            mem_wb_flush = 1'b1;
        end else if (take_redirect) begin
            pc_we       = 1'b1;
            pc_sel      = 1'b1;
            if_id_we    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_we    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_we   = 1'b1;
        end else if (take_bubble) begin
            // Hold IF and ID, and inject one bubble into EX.
            id_ex_we    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_we   = 1'b1;
        end else begin
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
        end
    end

    assign stall   = ~pc_we;
    assign mem_err = mem_err_reg;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_INIT;
            bub_cnt_reg  <= '0;
            wait_cnt_reg <= 8'd0;
            mem_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bub_cnt_reg  <= bub_cnt_next;
            wait_cnt_reg <= wait_cnt_next;
            mem_err_reg  <= mem_err_next;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef PIPE_PERF_CNT_EN
    logic [3:0]  perf_inc;
    logic [31:0] perf_cnt_reg [4];

    // Counter index map: 0 = cycles, 1 = load-use bubbles,
    //                    2 = memory stalls, 3 = redirects.
    assign perf_inc[0] = active;
    assign perf_inc[1] = take_bubble;
    assign perf_inc[2] = memstall;
    assign perf_inc[3] = take_redirect;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_perf
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    perf_cnt_reg[gi] <= 32'd0;
                end else if (perf_inc[gi]) begin
                    perf_cnt_reg[gi] <= perf_cnt_reg[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign perf_cycles = perf_cnt_reg[0];
    assign perf_lu     = perf_cnt_reg[1];
    assign perf_mem    = perf_cnt_reg[2];
    assign perf_flush  = perf_cnt_reg[3];
`else
    assign perf_cycles = 32'd0;
    assign perf_lu     = 32'd0;
    assign perf_mem    = 32'd0;
    assign perf_flush  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// This bench drives pipe_hazard_ctrl (RST_BUBBLES=4, MEM_TIMEOUT=5) with two
// kinds of stimulus:
//   - a table of directed vectors, each with hand-computed expected outputs,
//   - hand-written sequences for the watchdog and for reset during a memory
//     access.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lu_stop, ex_redirect, mem_req, mem_ready;
    logic        pc_we, pc_sel, if_id_we, if_id_flush, id_ex_we, id_ex_flush;
    logic        ex_mem_we, ex_mem_flush, mem_wb_flush, stall, mem_err;
    logic [31:0] perf_cycles, perf_lu, perf_mem, perf_flush;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .RST_BUBBLES (4),
        .MEM_TIMEOUT (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lu_stop      (lu_stop),
        .ex_redirect  (ex_redirect),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .if_id_we     (if_id_we),
        .if_id_flush  (if_id_flush),
        .id_ex_we     (id_ex_we),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_we    (ex_mem_we),
        .ex_mem_flush (ex_mem_flush),
        .mem_wb_flush (mem_wb_flush),
        .stall        (stall),
        .mem_err      (mem_err),
        .perf_cycles  (perf_cycles),
        .perf_lu      (perf_lu),
        .perf_mem     (perf_mem),
        .perf_flush   (perf_flush)
    );

    // Output bit order:
    //   {pc_we, pc_sel, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
    //    ex_mem_we, ex_mem_flush, mem_wb_flush, stall}
    localparam logic [9:0] O_INIT  = 10'b0001010111;
    localparam logic [9:0] O_RUN   = 10'b1010101000;
    localparam logic [9:0] O_REDIR = 10'b1111111000;
    localparam logic [9:0] O_LU    = 10'b0000111001;
    localparam logic [9:0] O_MEM   = 10'b0000000011;

    logic [9:0] outs;
    assign outs = {pc_we, pc_sel, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
                   ex_mem_we, ex_mem_flush, mem_wb_flush, stall};

    typedef struct {
        logic       lu;
        logic       redir;
        logic       req;
        logic       ready;
        logic [9:0] exp;
        logic       exp_err;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input logic lu, input logic redir, input logic req,
                           input logic ready, input logic [9:0] exp);
        vec_t v;
        v.lu = lu; v.redir = redir; v.req = req; v.ready = ready;
        v.exp = exp; v.exp_err = 1'b0;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic lu, input logic redir, input logic req,
                         input logic ready);
        lu_stop = lu; ex_redirect = redir; mem_req = req; mem_ready = ready;
    endtask

    // Call this on the negedge where rst_n has just been released. It counts
    // the cycles with pc_we low up to the first PC advance, with a bound.
    task automatic count_init(output int n);
        n = 0;
        #1;
        while (!pc_we && n < 20) begin
            n++;
            @(negedge clk);
            #1;
        end
    endtask

    int n;

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0);

        // INIT cycles: the inputs should be ignored.
        add_vec(1, 1, 1, 0, O_INIT);
        add_vec(1, 0, 0, 0, O_INIT);
        add_vec(0, 1, 1, 1, O_INIT);
        add_vec(0, 0, 1, 0, O_INIT);
        // First PC advance on the 5th cycle.
        add_vec(0, 0, 0, 0, O_RUN);
        // A single load-use bubble.
        add_vec(1, 0, 0, 0, O_LU);
        add_vec(0, 0, 0, 0, O_RUN);
        // A redirect together with lu_stop: the redirect wins.
        add_vec(1, 1, 0, 0, O_REDIR);
        add_vec(0, 0, 0, 0, O_RUN);
        // A zero-wait memory access.
        add_vec(0, 0, 1, 1, O_RUN);
        // Three stall cycles, then release.
        add_vec(0, 0, 1, 0, O_MEM);
        add_vec(0, 0, 1, 0, O_MEM);
        add_vec(0, 0, 1, 0, O_MEM);
        add_vec(0, 0, 1, 1, O_RUN);
        add_vec(0, 0, 0, 0, O_RUN);
        // A redirect held through a 2-cycle stall.
        add_vec(0, 1, 1, 0, O_MEM);
        add_vec(0, 1, 1, 0, O_MEM);
        add_vec(0, 1, 1, 1, O_REDIR);
        add_vec(0, 0, 0, 0, O_RUN);
        // lu_stop held through a stall, applied on the release cycle.
        add_vec(1, 0, 1, 0, O_MEM);
        add_vec(1, 0, 1, 1, O_LU);
        add_vec(0, 0, 0, 0, O_RUN);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_outs", {22'd0, outs}, {22'd0, O_INIT});
        check("reset_mem_err", {31'd0, mem_err}, 32'd0);
        check("reset_perf", perf_cycles | perf_lu | perf_mem | perf_flush, 32'd0);

        // Table-driven phase
        rst_n = 1'b1;
        for (int i = 0; i < vq.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(vq[i].lu, vq[i].redir, vq[i].req, vq[i].ready);
            #1;
            $display("vec %0d lu=%b rd=%b rq=%b rdy=%b outs=%b exp=%b err=%b",
                     i, vq[i].lu, vq[i].redir, vq[i].req, vq[i].ready,
                     outs, vq[i].exp, mem_err);
            check($sformatf("vec%0d_outs", i), {22'd0, outs}, {22'd0, vq[i].exp});
            check($sformatf("vec%0d_err", i), {31'd0, mem_err}, {31'd0, vq[i].exp_err});
        end
        drive(0, 0, 0, 0);
        @(negedge clk);
        #1;
`ifdef PIPE_PERF_CNT_EN
        check("perf_cycles", perf_cycles, 32'd18);
        check("perf_lu", perf_lu, 32'd2);
        check("perf_mem", perf_mem, 32'd6);
        check("perf_flush", perf_flush, 32'd2);
`else
        check("perf_tied", perf_cycles | perf_lu | perf_mem | perf_flush, 32'd0);
`endif

        // Watchdog: mem_ready held low with MEM_TIMEOUT=5.
        drive(0, 0, 1, 0);
        #1;
        $display("wd enter outs=%b err=%b", outs, mem_err);
        check("wd_enter_outs", {22'd0, outs}, {22'd0, O_MEM});
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            #1;
            $display("wd wait %0d outs=%b err=%b", k, outs, mem_err);
            check($sformatf("wd_wait%0d_err", k), {31'd0, mem_err}, 32'd0);
        end
        @(negedge clk);
        #1;
        $display("wd timeout outs=%b err=%b", outs, mem_err);
        check("wd_err_set", {31'd0, mem_err}, 32'd1);
        check("wd_still_stalled", {22'd0, outs}, {22'd0, O_MEM});
        drive(0, 0, 1, 1);
        #1;
        check("wd_release_outs", {22'd0, outs}, {22'd0, O_RUN});
        check("wd_release_err", {31'd0, mem_err}, 32'd1);
        @(negedge clk);
        drive(0, 0, 0, 0);
        #1;
        check("wd_sticky_err", {31'd0, mem_err}, 32'd1);
        check("wd_after_outs", {22'd0, outs}, {22'd0, O_RUN});
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        $display("wd reset outs=%b err=%b", outs, mem_err);
        check("wd_err_cleared", {31'd0, mem_err}, 32'd0);
        check("wd_reset_outs", {22'd0, outs}, {22'd0, O_INIT});

        // Reset release: count the INIT cycles.
        rst_n = 1'b1;
        count_init(n);
        $display("init count=%0d outs=%b", n, outs);
        check("init_len_1", n, 32'd4);
        check("init_first_run", {22'd0, outs}, {22'd0, O_RUN});

        // Reset in the middle of a memory access.
        drive(0, 0, 1, 0);
        #1;
        check("mid_stall0", {31'd0, stall}, 32'd1);
        @(negedge clk);
        #1;
        check("mid_stall1", {22'd0, outs}, {22'd0, O_MEM});
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        $display("mid reset outs=%b", outs);
        check("mid_reset_outs", {22'd0, outs}, {22'd0, O_INIT});
        drive(0, 0, 0, 0);
        rst_n = 1'b1;
        count_init(n);
        $display("init count=%0d outs=%b", n, outs);
        check("init_len_2", n, 32'd4);
        check("init_run_2", {22'd0, outs}, {22'd0, O_RUN});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Combines the load-use stop from the forwarding/hazard unit, EX-stage branch/jump redirect and the multi-cycle data-memory handshake.
- Drives write-enable and flush for PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Owns the post-reset pipeline-clear sequence and a memory-wait watchdog.

Parameters:
- RST_BUBBLES, 4: cycles spent flushing all pipeline registers after reset (>=1).
- MEM_TIMEOUT, 255: MEM_WAIT cycles before mem_err is raised (>=1, fits 8 bits).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- lu_stop  in  1  load-use hazard from hazard unit (ID needs a load result still in EX).
- ex_redirect  in  1  taken branch / jal / jalr resolved in EX.
- mem_req  in  1  MEM stage holds a load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_we  out  1  PC register load enable.
- pc_sel  out  1  0 = PC+4, 1 = EX redirect target.
- if_id_we  out  1  IF/ID enable.
- if_id_flush  out  1  IF/ID clear to NOP.
- id_ex_we  out  1  ID/EX enable.
- id_ex_flush  out  1  ID/EX clear to NOP.
- ex_mem_we  out  1  EX/MEM enable.
- ex_mem_flush  out  1  EX/MEM clear to NOP.
- mem_wb_flush  out  1  MEM/WB clear to NOP (MEM/WB has no enable).
- stall  out  1  high on any cycle where pc_we=0.
- mem_err  out  1  sticky watchdog flag.
- perf_cycles, perf_lu, perf_mem, perf_flush  out  32 each  performance counters (see Optional Feature).

Behaviour:
- Control outputs are combinational from state and inputs; state, counters and mem_err are registered.
- Flush overrides we at every pipeline register.
- States: INIT, RUN, MEM_WAIT.
- Reset (rst_n=0 at posedge):
  - state=INIT, bubble counter=0, wait counter=0, mem_err=0, perf counters=0.
  - Reset mid-access discards MEM_WAIT immediately.
- INIT:
  - pc_we=0; all four flushes=1; pc_sel=0; stall=1.
  - Counter increments each cycle; after RST_BUBBLES INIT cycles, go to RUN.
  - First PC advance occurs RST_BUBBLES+1 cycles after reset release.
  - All inputs are ignored in INIT.
- Memory stall condition memstall = mem_req & !mem_ready (RUN) or !mem_ready (MEM_WAIT).
  - Outputs: pc_we=if_id_we=id_ex_we=ex_mem_we=0; mem_wb_flush=1; all other flushes=0; pc_sel=0.
  - lu_stop and ex_redirect are ignored; they are re-evaluated once the stall clears, because their source stages are frozen.
- RUN with memstall: go to MEM_WAIT, wait counter=1.
- MEM_WAIT:
  - While !mem_ready: increment wait counter, saturating.
  - When wait counter reaches MEM_TIMEOUT: mem_err=1, held until reset. The state stays in MEM_WAIT.
  - When mem_ready=1: the release cycle uses normal RUN decode (redirect/lu apply that same cycle); go to RUN; wait counter=0.
- RUN decode, no memstall, highest priority first:
  - ex_redirect:
    - pc_we=1, pc_sel=1, if_id_flush=1, id_ex_flush=1, other enables=1.
    - lu_stop is ignored, because the stalled instruction is squashed.
  - lu_stop:
    - pc_we=0, if_id_we=0, id_ex_flush=1, ex_mem_we=1.
    - Exactly one bubble per assertion; the hazard unit deasserts the following cycle.
  - Otherwise: all enables=1, all flushes=0.
- mem_req with mem_ready=1 in the same RUN cycle is zero-wait: no stall, stays in RUN.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - perf_cycles counts RUN+MEM_WAIT cycles.
  - perf_lu counts lu_stop bubbles actually inserted.
  - perf_mem counts memstall cycles.
  - perf_flush counts redirects taken.
  - All counters wrap modulo 2^32 and clear on reset.
- Undefined: counter logic is omitted; the four perf ports remain and are tied to 0.

Test Plan:
- Reset with RST_BUBBLES=4, release rst_n -> flushes=1 and pc_we=0 for exactly 4 cycles; pc_we=1 on the 5th cycle.
- lu_stop=1 for one RUN cycle -> that cycle pc_we=0, if_id_we=0, id_ex_flush=1, ex_mem_we=1; next cycle all enables=1.
- ex_redirect=1 and lu_stop=1 together -> pc_sel=1, pc_we=1, if_id_flush=1, id_ex_flush=1; no stall.
- mem_req=1, mem_ready low for 3 cycles then high -> 3 stall cycles with mem_wb_flush=1 and pc_we=0; release cycle all enables=1; perf_mem=3 with PIPE_PERF_CNT_EN.
- ex_redirect=1 during a 2-cycle memstall -> redirect suppressed while stalled; pc_sel=1 exactly on the mem_ready cycle.
- MEM_TIMEOUT=5, mem_ready held 0 -> mem_err rises after the 5th MEM_WAIT cycle; stays 1 after mem_ready=1 until rst_n=0.
